// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// master = requesters plus RAM side, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_stall;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_address, ram_data, ram_wren,
    input  ram_q
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: round-robin on conflict,
// with a bounded locked-burst mode for port B and in-order read return.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input logic        clock,
  input logic        reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } winner_e;

  winner_e           last_winner_q, last_winner_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              a_pend_q, a_pend_d;
  logic              b_pend_q, b_pend_d;

  logic              a_gnt, b_gnt;
  logic              burst_active, burst_sat;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;
  logic              mux_we;

  // A nonzero count implies B was granted last cycle, since it clears otherwise.
  assign burst_sat    = (burst_cnt_q == CNT_MAX);
  assign burst_active = bus.b_req & bus.b_lock & (burst_cnt_q != '0) & (burst_cnt_q < CNT_MAX);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin
        if (burst_active) begin
          b_gnt = 1'b1;
        end else if (burst_sat) begin
          a_gnt = 1'b1;
        end else if (last_winner_q == WIN_B) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = 1'b1;
        end
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (a_gnt) begin
      last_winner_d = WIN_A;
    end else if (b_gnt) begin
      last_winner_d = WIN_B;
    end

    burst_cnt_d = '0;
    if (b_gnt) begin
      burst_cnt_d = burst_sat ? burst_cnt_q : burst_cnt_q + 1'b1;
    end

    a_pend_d = a_gnt & ~bus.a_we;
    b_pend_d = b_gnt & ~bus.b_we;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner_q <= WIN_B;
      burst_cnt_q   <= '0;
      a_pend_q      <= 1'b0;
      b_pend_q      <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      a_pend_q      <= a_pend_d;
      b_pend_q      <= b_pend_d;
    end
  end

  // Port A owns the RAM bus whenever B is not granted, including idle cycles.
  always_comb begin
    mux_addr = bus.a_addr;
    mux_data = bus.a_wdata;
    mux_we   = a_gnt & bus.a_we;
    if (b_gnt) begin
      mux_addr = bus.b_addr;
      mux_data = bus.b_wdata;
      mux_we   = bus.b_we;
    end
  end

  assign bus.ram_address = mux_addr;
  assign bus.ram_data    = mux_data;
  assign bus.ram_wren    = mux_we;

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_stall  = bus.a_req & ~a_gnt;
  // Gating with reset drops a read whose data cycle coincides with reset.
  assign bus.a_rvalid = a_pend_q & ~reset;
  assign bus.b_rvalid = b_pend_q & ~reset;
  assign bus.a_rdata  = bus.ram_q;
  assign bus.b_rdata  = bus.ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM
// (registered address, one-cycle read latency).
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [15:0] mem [0:65535];
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_lock = 1'b0;
    bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'h5A00 ^ a;
  endfunction

  logic        exp_b;
  logic        prev_valid, prev_b;
  logic [15:0] aa, ba, prev_addr;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));

    // reset behaviour with every request asserted
    idle();
    reset = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.b_req = 1'b1; bus.b_we = 1'b1;
    next_cyc();
    next_cyc();
    sample();
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_wren", bus.ram_wren, 0);
    chk("rst_a_stall", bus.a_stall, 1);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    bus.a_req = 1'b0;
    #1;
    chk("rst_a_stall_lo", bus.a_stall, 0);

    // first conflict after reset goes to A, reads return in order
    next_cyc();
    reset = 1'b0;
    idle();
    bus.a_req = 1'b1; bus.a_addr = 16'h0010;
    bus.b_req = 1'b1; bus.b_addr = 16'h0020;
    sample();
    chk("c0_a_gnt", bus.a_gnt, 1);
    chk("c0_b_gnt", bus.b_gnt, 0);
    chk("c0_addr", bus.ram_address, 16'h0010);
    chk("c0_wren", bus.ram_wren, 0);
    next_cyc();
    bus.a_req = 1'b0;
    sample();
    chk("c1_b_gnt", bus.b_gnt, 1);
    chk("c1_addr", bus.ram_address, 16'h0020);
    chk("c1_a_rvalid", bus.a_rvalid, 1);
    chk("c1_a_rdata", bus.a_rdata, init_val(16'h0010));
    chk("c1_b_rvalid", bus.b_rvalid, 0);
    next_cyc();
    bus.b_req = 1'b0;
    sample();
    chk("c2_b_rvalid", bus.b_rvalid, 1);
    chk("c2_b_rdata", bus.b_rdata, init_val(16'h0020));
    chk("c2_a_rvalid", bus.a_rvalid, 0);

    // locked B burst starves A for at most MAX_BURST grants
    next_cyc();
    idle();
    bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_we = 1'b1;
    bus.a_addr = 16'h0030;
    for (int c = 0; c <= 8; c++) begin
      bus.b_addr  = 16'h1000 + 16'(c);
      bus.b_wdata = 16'hC000 + 16'(c);
      bus.a_req   = (c >= 1);
      sample();
      chk($sformatf("burst%0d_b_gnt", c), bus.b_gnt, (c <= 7));
      chk($sformatf("burst%0d_a_gnt", c), bus.a_gnt, (c == 8));
      chk($sformatf("burst%0d_a_stall", c), bus.a_stall, (c >= 1 && c <= 7));
      if (c <= 7) chk($sformatf("burst%0d_addr", c), bus.ram_address, 16'h1000 + 16'(c));
      next_cyc();
    end
    idle();
    sample();
    chk("burst_a_rvalid", bus.a_rvalid, 1);
    chk("burst_a_rdata", bus.a_rdata, init_val(16'h0030));
    chk("burst_mem_1003", mem[16'h1003], 16'hC003);

    // saturated burst keeps B granted while A is idle, then yields at once
    next_cyc();
    idle();
    bus.b_req = 1'b1; bus.b_lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.b_addr = 16'h0040 + 16'(c);
      sample();
      chk($sformatf("sat%0d_b_gnt", c), bus.b_gnt, 1);
      next_cyc();
    end
    bus.a_req = 1'b1; bus.a_addr = 16'h0050;
    sample();
    chk("sat_a_gnt", bus.a_gnt, 1);
    chk("sat_b_gnt", bus.b_gnt, 0);
    chk("sat_b_rvalid", bus.b_rvalid, 1);
    chk("sat_b_rdata", bus.b_rdata, init_val(16'h0049));
    next_cyc();
    idle();
    sample();
    chk("sat_a_rdata", bus.a_rdata, init_val(16'h0050));

    // write then read the same address on A
    next_cyc();
    idle();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0100; bus.a_wdata = 16'hBEEF;
    sample();
    chk("wr_a_gnt", bus.a_gnt, 1);
    chk("wr_wren", bus.ram_wren, 1);
    chk("wr_data", bus.ram_data, 16'hBEEF);
    next_cyc();
    bus.a_we = 1'b0;
    sample();
    chk("rd_wren", bus.ram_wren, 0);
    chk("rd_a_gnt", bus.a_gnt, 1);
    chk("wr_no_rvalid", bus.a_rvalid, 0);
    next_cyc();
    idle();
    bus.a_addr = 16'h0ABC; bus.a_wdata = 16'h1234;
    sample();
    chk("rd_a_rvalid", bus.a_rvalid, 1);
    chk("rd_a_rdata", bus.a_rdata, 16'hBEEF);
    chk("idle_wren", bus.ram_wren, 0);
    chk("idle_addr", bus.ram_address, 16'h0ABC);
    chk("idle_data", bus.ram_data, 16'h1234);

    // both requesting, no lock: strict alternation (A won last, so B first)
    next_cyc();
    idle();
    aa = 16'h0060; ba = 16'h0070;
    exp_b = 1'b1; prev_valid = 1'b0; prev_b = 1'b0; prev_addr = '0;
    for (int c = 0; c <= 6; c++) begin
      bus.a_req = (c < 6); bus.a_addr = aa;
      bus.b_req = (c < 6); bus.b_addr = ba;
      sample();
      if (c < 6) begin
        chk($sformatf("alt%0d_a_gnt", c), bus.a_gnt, !exp_b);
        chk($sformatf("alt%0d_b_gnt", c), bus.b_gnt, exp_b);
      end
      if (prev_valid) begin
        chk($sformatf("alt%0d_a_rvalid", c), bus.a_rvalid, !prev_b);
        chk($sformatf("alt%0d_b_rvalid", c), bus.b_rvalid, prev_b);
        chk($sformatf("alt%0d_rdata", c), prev_b ? bus.b_rdata : bus.a_rdata, init_val(prev_addr));
      end
      prev_valid = (c < 6);
      prev_b     = exp_b;
      prev_addr  = exp_b ? ba : aa;
      if (exp_b) ba = ba + 16'd1;
      else       aa = aa + 16'd1;
      exp_b = !exp_b;
      next_cyc();
    end

    // reset right after a B read grant
    idle();
    bus.b_req = 1'b1; bus.b_addr = 16'h0080;
    sample();
    chk("rb_b_gnt", bus.b_gnt, 1);
    next_cyc();
    reset = 1'b1;
    idle();
    sample();
    chk("rb_b_rvalid", bus.b_rvalid, 0);
    next_cyc();
    reset = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 16'h0090;
    bus.b_req = 1'b1; bus.b_addr = 16'h00A0;
    sample();
    chk("rb_a_gnt", bus.a_gnt, 1);
    chk("rb_b_gnt", bus.b_gnt, 0);
    next_cyc();
    idle();
    sample();
    chk("rb_a_rdata", bus.a_rdata, init_val(16'h0090));

    // reset right after an A read grant; reset must restore A's priority
    next_cyc();
    bus.a_req = 1'b1; bus.a_addr = 16'h00B0;
    sample();
    chk("ra_a_gnt", bus.a_gnt, 1);
    next_cyc();
    reset = 1'b1;
    idle();
    sample();
    chk("ra_a_rvalid", bus.a_rvalid, 0);
    next_cyc();
    reset = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 16'h00C0;
    bus.b_req = 1'b1; bus.b_addr = 16'h00D0;
    sample();
    chk("ra_conf_a_gnt", bus.a_gnt, 1);
    chk("ra_conf_b_gnt", bus.b_gnt, 0);
    next_cyc();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
